// File: rtl/round_sequencer_if.sv
// Handshake bundle between the round sequencer and its picker, drawer and note player.
interface round_sequencer_if;
  logic        pick_start;
  logic        pick_done;
  logic [10:0] x_loc;
  logic [10:0] y_loc;
  logic        draw_start;
  logic        draw_color;
  logic        draw_done;
  logic [10:0] x0;
  logic [10:0] y0;
  logic        play_start;
  logic        play_done;

  modport master (
    output pick_start, draw_start, draw_color, x0, y0, play_start,
    input  pick_done, x_loc, y_loc, draw_done, play_done
  );

  modport slave (
    input  pick_start, draw_start, draw_color, x0, y0, play_start,
    output pick_done, x_loc, y_loc, draw_done, play_done
  );
endinterface

// File: rtl/round_sequencer.sv
// Game round controller: picks a square, draws it, plays a note, waits for a
// click inside the square or a timeout, erases it, and repeats for MAX_ROUNDS.
module round_sequencer #(
  parameter int SQUARE_SIZE   = 20,
  parameter int TIMEOUT_TICKS = 3,
  parameter int MAX_ROUNDS    = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                tick,
  input  logic                click,
  input  logic [10:0]         mouse_x,
  input  logic [10:0]         mouse_y,
  round_sequencer_if.master   bus,
  output logic                point,
  output logic                miss,
  output logic                game_done,
  output logic [3:0]          round,
  output logic                busy
);

  localparam int CNT_W = (TIMEOUT_TICKS < 2) ? 1 : $clog2(TIMEOUT_TICKS + 1);
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TIMEOUT_TICKS - 1);
  localparam logic [11:0]      SPAN      = 12'(SQUARE_SIZE - 1);
  localparam logic [3:0]       ROUND_MAX = 4'(MAX_ROUNDS);

  typedef enum logic [2:0] {
    S_IDLE, S_PICK, S_DRAW, S_PLAY, S_WAIT, S_ERASE, S_FINISH
  } state_t;

  state_t             state_q, state_d;
  logic               pick_start_q, pick_start_d;
  logic               draw_start_q, draw_start_d;
  logic               play_start_q, play_start_d;
  logic               draw_color_q, draw_color_d;
  logic               point_q, point_d;
  logic               miss_q, miss_d;
  logic               game_done_q, game_done_d;
  logic [10:0]        x0_q, x0_d;
  logic [10:0]        y0_q, y0_d;
  logic [3:0]         round_q, round_d;
  logic [CNT_W-1:0]   tick_cnt_q, tick_cnt_d;
  logic               click_prev_q, click_prev_d;

  logic [11:0] x_lo, x_hi, y_lo, y_hi, mx, my;
  logic        in_square, hit;

  // Twelve-bit bounds so a square near the right/bottom edge cannot wrap.
  always_comb begin
    x_lo      = {1'b0, x0_q};
    y_lo      = {1'b0, y0_q};
    x_hi      = x_lo + SPAN;
    y_hi      = y_lo + SPAN;
    mx        = {1'b0, mouse_x};
    my        = {1'b0, mouse_y};
    in_square = (mx >= x_lo) && (mx <= x_hi) && (my >= y_lo) && (my <= y_hi);
    hit       = click && !click_prev_q && in_square;
  end

  always_comb begin
    state_d      = state_q;
    pick_start_d = 1'b0;
    draw_start_d = 1'b0;
    play_start_d = 1'b0;
    point_d      = 1'b0;
    miss_d       = 1'b0;
    game_done_d  = 1'b0;
    draw_color_d = draw_color_q;
    x0_d         = x0_q;
    y0_d         = y0_q;
    round_d      = round_q;
    tick_cnt_d   = tick_cnt_q;
    click_prev_d = click;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d      = S_PICK;
          pick_start_d = 1'b1;
          round_d      = 4'd0;
        end
      end
      S_PICK: begin
        if (bus.pick_done) begin
          x0_d         = bus.x_loc;
          y0_d         = bus.y_loc;
          state_d      = S_DRAW;
          draw_start_d = 1'b1;
          draw_color_d = 1'b1;
        end
      end
      S_DRAW: begin
        if (bus.draw_done) begin
          state_d      = S_PLAY;
          play_start_d = 1'b1;
        end
      end
      S_PLAY: begin
        if (bus.play_done) begin
          state_d      = S_WAIT;
          tick_cnt_d   = '0;
          click_prev_d = 1'b0;
        end
      end
      S_WAIT: begin
        // A hit outranks a timeout landing in the same cycle.
        if (hit || (tick && tick_cnt_q == TICK_LAST)) begin
          point_d      = hit;
          miss_d       = !hit;
          state_d      = S_ERASE;
          draw_start_d = 1'b1;
          draw_color_d = 1'b0;
          round_d      = (round_q >= ROUND_MAX) ? round_q : round_q + 4'd1;
        end else if (tick) begin
          tick_cnt_d = tick_cnt_q + CNT_W'(1);
        end
      end
      S_ERASE: begin
        if (bus.draw_done) begin
          if (round_q >= ROUND_MAX) begin
            state_d     = S_FINISH;
            game_done_d = 1'b1;
          end else begin
            state_d      = S_PICK;
            pick_start_d = 1'b1;
          end
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      pick_start_q <= 1'b0;
      draw_start_q <= 1'b0;
      play_start_q <= 1'b0;
      draw_color_q <= 1'b0;
      point_q      <= 1'b0;
      miss_q       <= 1'b0;
      game_done_q  <= 1'b0;
      x0_q         <= '0;
      y0_q         <= '0;
      round_q      <= '0;
      tick_cnt_q   <= '0;
      click_prev_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pick_start_q <= pick_start_d;
      draw_start_q <= draw_start_d;
      play_start_q <= play_start_d;
      draw_color_q <= draw_color_d;
      point_q      <= point_d;
      miss_q       <= miss_d;
      game_done_q  <= game_done_d;
      x0_q         <= x0_d;
      y0_q         <= y0_d;
      round_q      <= round_d;
      tick_cnt_q   <= tick_cnt_d;
      click_prev_q <= click_prev_d;
    end
  end

  assign bus.pick_start = pick_start_q;
  assign bus.draw_start = draw_start_q;
  assign bus.play_start = play_start_q;
  assign bus.draw_color = draw_color_q;
  assign bus.x0         = x0_q;
  assign bus.y0         = y0_q;
  assign point          = point_q;
  assign miss           = miss_q;
  assign game_done      = game_done_q;
  assign round          = round_q;
  assign busy           = (state_q != S_IDLE);

endmodule

// File: doc/round_sequencer.md
ROUND_SEQUENCER -- requirements
Module: round_sequencer

Interface
REQ-001 Parameter SQUARE_SIZE, default 20, edge length in pixels of the drawn square.
REQ-002 Parameter TIMEOUT_TICKS, default 3, tick pulses allowed per round before a miss.
REQ-003 Parameter MAX_ROUNDS, default 10, rounds per game.
REQ-004 clk  input  1  system clock (CLOCK_50 domain); all logic on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  single-cycle pulse that begins a game.
REQ-007 tick  input  1  single-cycle 1 Hz timing pulse.
REQ-008 pick_done  input  1  location picker finished; x_loc/y_loc valid this cycle.
REQ-009 x_loc, y_loc  input  11 each  picked square origin.
REQ-010 draw_done  input  1  square drawer finished.
REQ-011 play_done  input  1  note player finished.
REQ-012 click  input  1  mouse left-button level.
REQ-013 mouse_x, mouse_y  input  11 each  cursor position.
REQ-014 pick_start, draw_start, play_start  output  1 each  single-cycle start pulses to picker, drawer, note player.
REQ-015 draw_color  output  1  1 = draw square white, 0 = erase (black); stable from draw_start until draw_done.
REQ-016 x0, y0  output  11 each  latched square origin fed to drawer.
REQ-017 point, miss, game_done  output  1 each  single-cycle result pulses.
REQ-018 round  output  4  rounds completed in current game.
REQ-019 busy  output  1  high in every state except IDLE.

Function
REQ-020 States: IDLE, PICK, DRAW, PLAY, WAIT, ERASE, FINISH; one state register, binary or one-hot.
REQ-021 IDLE: start=1 -> PICK, round cleared to 0, pick_start pulsed on the transition cycle's next edge (one cycle high).
REQ-022 PICK: on pick_done, latch x_loc/y_loc into x0/y0, go DRAW, pulse draw_start with draw_color=1.
REQ-023 DRAW: on draw_done -> PLAY, pulse play_start.
REQ-024 PLAY: on play_done -> WAIT, clear tick counter and click history.
REQ-025 WAIT: click rising edge (click=1, previous-cycle click=0) with x0 <= mouse_x <= x0+SQUARE_SIZE-1 and y0 <= mouse_y <= y0+SQUARE_SIZE-1 -> pulse point, go ERASE.
REQ-026 Hit comparison computed in 12 bits; x0+SQUARE_SIZE-1 shall not wrap.
REQ-027 WAIT: click rising edge outside the square is ignored; no pulse, no state change.
REQ-028 WAIT: tick increments counter; when counter reaches TIMEOUT_TICKS -> pulse miss, go ERASE.
REQ-029 Hit and final timeout tick in the same cycle: hit wins; point pulses, miss does not.
REQ-030 Entering ERASE pulses draw_start with draw_color=0, same x0/y0; round increments by 1 on entry.
REQ-031 ERASE: on draw_done, round==MAX_ROUNDS -> FINISH, else -> PICK with pick_start pulse.
REQ-032 FINISH: pulse game_done one cycle, return to IDLE; round holds its final value.
REQ-033 start while busy is ignored; done inputs arriving in a state not waiting for them are ignored.
REQ-034 Each start/result pulse shall be exactly one cycle, registered (no combinational path from inputs).
REQ-035 round saturates at MAX_ROUNDS, never wraps.

Reset
REQ-036 reset low, at any time including mid-draw: state=IDLE; all pulses, draw_color, busy = 0; x0=y0=0; round=0; tick counter and click history cleared.
REQ-037 After reset release, no output pulses until start.

Verification
REQ-038 start; pick_done with x_loc=100,y_loc=50; draw_done; play_done; click at (105,60) -> draw_start(color 1) with x0=100,y0=50, then point one cycle, draw_start(color 0), round=1.
REQ-039 Same setup, click at (120,60) (edge+1) then 3 ticks -> no point, miss on 3rd tick, erase, round=1.
REQ-040 Click rising edge at (119,69) in the same cycle as 3rd tick -> point=1, miss=0.
REQ-041 MAX_ROUNDS=2: two full rounds -> game_done one cycle after 2nd erase draw_done, busy=0, round=2.
REQ-042 reset low while in DRAW, then start ignored during reset -> all outputs 0; after release, pick_start only after new start.
REQ-043 Spurious draw_done/play_done in IDLE and start pulse in WAIT -> no state change, no output pulses.
